// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: arbitrates inst/data SRAM-like requesters onto one bus with in-order response routing.
// Optional ARB_ROUND_ROBIN_EN alternates grants on contention; default favours the data side.
module sram_req_arbiter #(
    parameter int OUTST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int AW = $clog2(OUTST_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(OUTST_DEPTH);

    logic [OUTST_DEPTH-1:0] ids;
    logic [AW-1:0]          head, tail;
    logic [CW-1:0]          count;
    logic                   locked, lock_id, gnt, both_pick, blocked, hs, pop;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;
    assign both_pick = ~last;
    always_ff @(posedge clk) begin
        if (reset) last <= 1'b0;
        else if (hs) last <= gnt;
    end
`else
    assign both_pick = 1'b1;
`endif

    // gnt: 0 = inst, 1 = data; a stalled request keeps its grant until accepted
    assign gnt     = locked ? lock_id : (inst_req && data_req) ? both_pick : data_req;
    assign blocked = count == FULL;
    assign mem_req = (gnt ? data_req : inst_req) && !blocked;
    assign hs      = mem_req && mem_addr_ok;
    assign pop     = mem_data_ok && (count != '0) && !reset;

    assign mem_wr    = gnt ? data_wr    : inst_wr;
    assign mem_size  = gnt ? data_size  : inst_size;
    assign mem_wstrb = gnt ? data_wstrb : 4'b0000;
    assign mem_addr  = gnt ? data_addr  : inst_addr;
    assign mem_wdata = gnt ? data_wdata : inst_wdata;

    assign inst_addr_ok = hs && !gnt;
    assign data_addr_ok = hs && gnt;
    assign inst_data_ok = pop && !ids[head];
    assign data_data_ok = pop && ids[head];
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            locked  <= 1'b0;
            lock_id <= 1'b0;
        end else begin
            locked  <= mem_req && !mem_addr_ok;
            lock_id <= gnt;
            if (hs) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + CW'(hs) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (hs) ids[tail] <= gnt;
    end
endmodule
